// File: rtl/csa_final_adder.sv
// -----------------------------------------------------------------------------
// csa_final_adder
//
// Purpose:
//   Final carry-propagate stage behind the 32-operand carry-save adder tree.
//   It takes the sum vector and the carry vector from the tree and produces
//   result = in_sum + in_carry (mod 2^WIDTH).
//   The carry vector is already aligned to its weight.
//
//   The adder is split into STAGES = WIDTH/CHUNK pipeline stages. Stage k
//   resolves operand chunk k and uses the carry that stage k-1 registered.
//   Operand chunks that are not yet consumed travel down the pipe with the
//   operation. Result chunks that are already resolved also travel down the
//   pipe, so all of them leave together.
//
//   A valid bit and an opaque tag move through every stage with the data.
//   The datapath can then match results to requests.
//
//   Latency is STAGES cycles and throughput is one operation per cycle.
//   There is no back-pressure.
//
// Parameters:
//   WIDTH  operand/result width; must be an integer multiple of CHUNK
//   CHUNK  bits resolved per pipeline stage
//   TAG_W  side-band tag width
//
// Ports:
//   clock       rising-edge clock
//   reset       synchronous active-high reset; clears every register
//   in_valid    a new operation is presented this cycle
//   in_sum      sum vector from the tree
//   in_carry    weight-aligned carry vector from the tree
//   in_tag      tag returned unchanged with the result
//   flush       clears every stage valid bit; the data registers keep loading
//   out_valid   out_result/out_tag hold a finished operation
//   out_result  (in_sum + in_carry) mod 2^WIDTH
//   out_tag     tag of the operation in out_result
//   busy        some stage holds a valid operation
//   perf_count  (only with CSA_FINAL_ADDER_PERF_EN) number of cycles with
//               out_valid=1 since reset; wraps modulo 2^32
//
// Optional feature macro: CSA_FINAL_ADDER_PERF_EN
// -----------------------------------------------------------------------------
module csa_final_adder #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16,
  parameter int TAG_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_sum,
  input  logic [WIDTH-1:0] in_carry,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
`ifdef CSA_FINAL_ADDER_PERF_EN
  ,
  output logic [31:0]      perf_count
`endif
);

  localparam int STAGES = WIDTH / CHUNK;

  // Mask covering chunk 0. It is shifted up to select the chunk that a
  // stage replaces in the result word.
  localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CHUNK{1'b1}});

  // ---------------------------------------------------------------------------
  // Pipeline registers. Entry k holds what stage k produced at the last edge.
  // ---------------------------------------------------------------------------
  logic [STAGES-1:0] valid_q;
  logic [TAG_W-1:0]  tag_q  [STAGES];
  logic [WIDTH-1:0]  sum_q  [STAGES];   // operand skew: sum vector
  logic [WIDTH-1:0]  car_q  [STAGES];   // operand skew: carry vector
  logic [WIDTH-1:0]  res_q  [STAGES];   // result skew: chunks 0..k resolved
  logic              cout_q [STAGES];   // carry out of chunk k

  // ---------------------------------------------------------------------------
  // Stage inputs: either the module ports (stage 0) or the previous stage.
  // ---------------------------------------------------------------------------
  logic [STAGES-1:0] stg_valid;
  logic [TAG_W-1:0]  stg_tag [STAGES];
  logic [WIDTH-1:0]  stg_sum [STAGES];
  logic [WIDTH-1:0]  stg_car [STAGES];
  logic [WIDTH-1:0]  stg_res [STAGES];
  logic              stg_cin [STAGES];

  // Next-state values computed by each stage's chunk adder
  logic [WIDTH-1:0]  res_d  [STAGES];
  logic              cout_d [STAGES];

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : stage_g
      logic [CHUNK:0] slice;

      if (gi == 0) begin : head_g
        assign stg_valid[gi] = in_valid;
        assign stg_tag[gi]   = in_tag;
        assign stg_sum[gi]   = in_sum;
        assign stg_car[gi]   = in_carry;
        assign stg_res[gi]   = '0;
        assign stg_cin[gi]   = 1'b0;
      end else begin : link_g
        assign stg_valid[gi] = valid_q[gi-1];
        assign stg_tag[gi]   = tag_q[gi-1];
        assign stg_sum[gi]   = sum_q[gi-1];
        assign stg_car[gi]   = car_q[gi-1];
        assign stg_res[gi]   = res_q[gi-1];
        assign stg_cin[gi]   = cout_q[gi-1];
      end

      // One CHUNK-wide add with carry-in. The extra top bit is the chunk
      // carry-out.
      assign slice = {1'b0, stg_sum[gi][gi*CHUNK +: CHUNK]}
                   + {1'b0, stg_car[gi][gi*CHUNK +: CHUNK]}
                   + {{CHUNK{1'b0}}, stg_cin[gi]};

      // The carry-out of the top stage is registered but never used.
      // That implements the modulo-2^WIDTH wrap.
      assign cout_d[gi] = slice[CHUNK];

      // Drop this stage's chunk into the result word and keep the chunks
      // that earlier stages already resolved.
      assign res_d[gi] = (stg_res[gi] & ~(CHUNK_MASK << (gi*CHUNK)))
                       | (WIDTH'(slice[CHUNK-1:0]) << (gi*CHUNK));
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Sequential state.
  // The data registers load every cycle. Only the valid bits care about
  // flush, so a flushed operation keeps moving through the pipe as harmless
  // garbage.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        tag_q[k]  <= '0;
        sum_q[k]  <= '0;
        car_q[k]  <= '0;
        res_q[k]  <= '0;
        cout_q[k] <= 1'b0;
      end
    end else begin
      valid_q <= flush ? '0 : stg_valid;
      for (int k = 0; k < STAGES; k++) begin
        tag_q[k]  <= stg_tag[k];
        sum_q[k]  <= stg_sum[k];
        car_q[k]  <= stg_car[k];
        res_q[k]  <= res_d[k];
        cout_q[k] <= cout_d[k];
      end
    end
  end

  assign out_valid  = valid_q[STAGES-1];
  assign out_result = res_q[STAGES-1];
  assign out_tag    = tag_q[STAGES-1];
  assign busy       = |valid_q;

`ifdef CSA_FINAL_ADDER_PERF_EN
  // Counts the cycles in which a result was presented. Flush leaves it alone.
  logic [31:0] perf_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_q <= '0;
    end else if (valid_q[STAGES-1]) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_count = perf_q;
`endif

endmodule

// File: tb/tb_csa_final_adder.sv
// -----------------------------------------------------------------------------
// tb_csa_final_adder
//
// Self-checking bench for csa_final_adder.
//
// The reference model is a queue of expected results. Each entry carries the
// cycle in which it must appear. An operation accepted at edge N is due on the
// outputs after edge N+STAGES-1. Flush or reset empties the queue.
//
// A compare process on the falling edge checks out_valid, busy, out_result,
// out_tag (and perf_count when CSA_FINAL_ADDER_PERF_EN is defined) against the
// queue. Some operations also carry a hand-computed literal result.
// -----------------------------------------------------------------------------
module tb_csa_final_adder;

  localparam int WIDTH  = 64;
  localparam int CHUNK  = 16;
  localparam int TAG_W  = 4;
  localparam int STAGES = WIDTH / CHUNK;

  logic             clock = 1'b0;
  logic             reset;
  logic             in_valid;
  logic [WIDTH-1:0] in_sum;
  logic [WIDTH-1:0] in_carry;
  logic [TAG_W-1:0] in_tag;
  logic             flush;
  logic             out_valid;
  logic [WIDTH-1:0] out_result;
  logic [TAG_W-1:0] out_tag;
  logic             busy;
`ifdef CSA_FINAL_ADDER_PERF_EN
  logic [31:0]      perf_count;
`endif

  always #5 clock = ~clock;

  csa_final_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK), .TAG_W(TAG_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_sum     (in_sum),
    .in_carry   (in_carry),
    .in_tag     (in_tag),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_result (out_result),
    .out_tag    (out_tag),
    .busy       (busy)
`ifdef CSA_FINAL_ADDER_PERF_EN
    ,
    .perf_count (perf_count)
`endif
  );

  typedef struct {
    int               due;
    logic [WIDTH-1:0] res;
    logic [TAG_W-1:0] tag;
    bit               has_lit;
    logic [WIDTH-1:0] lit;
  } exp_t;

  exp_t             exp_q[$];
  int               cyc      = 0;
  bit               armed    = 1'b0;
  bit               idle_chk = 1'b0;
  bit               lit_en   = 1'b0;
  logic [WIDTH-1:0] lit_val  = '0;
  int               seen     = 0;
  int               perf_exp = 0;
  int               n_cmp    = 0;
  int               n_bad    = 0;

  task automatic chk(input string nm, input logic [WIDTH-1:0] act,
                     input logic [WIDTH-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model update at every active edge.
  // Reset takes priority over flush, and flush takes priority over in_valid.
  always @(posedge clock) begin
    exp_t e;
    cyc = cyc + 1;
    if (reset) begin
      exp_q.delete();
      armed    = 1'b1;
      perf_exp = 0;
    end else if (flush) begin
      exp_q.delete();
    end else if (in_valid) begin
      e.due     = cyc + STAGES - 1;
      e.res     = in_sum + in_carry;
      e.tag     = in_tag;
      e.has_lit = lit_en;
      e.lit     = lit_val;
      exp_q.push_back(e);
    end
  end

  // Compare on the falling edge, away from the active edge.
  always @(negedge clock) begin
    bit ev;
    if (armed) begin
      while (exp_q.size() > 0 && exp_q[0].due < cyc) void'(exp_q.pop_front());
      ev = (exp_q.size() > 0) && (exp_q[0].due == cyc);
      chk("out_valid", {63'd0, out_valid}, {63'd0, ev});
      chk("busy", {63'd0, busy}, {63'd0, exp_q.size() > 0});
      if (ev && out_valid) begin
        $display("result tag=%0d result=%h", out_tag, out_result);
        chk("out_result", out_result, exp_q[0].res);
        chk("out_tag", {60'd0, out_tag}, {60'd0, exp_q[0].tag});
        if (exp_q[0].has_lit) chk("literal_result", out_result, exp_q[0].lit);
        seen++;
      end
      if (idle_chk) begin
        chk("idle_result", out_result, '0);
        chk("idle_tag", {60'd0, out_tag}, '0);
      end
`ifdef CSA_FINAL_ADDER_PERF_EN
      chk("perf_count", {32'd0, perf_count}, 64'(perf_exp));
      if (ev) perf_exp++;
`endif
    end
  end

  task automatic step(input bit v, input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] c,
                      input logic [TAG_W-1:0] t, input bit f, input bit r);
    in_valid = v;
    in_sum   = s;
    in_carry = c;
    in_tag   = t;
    flush    = f;
    reset    = r;
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic op(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] c,
                    input logic [TAG_W-1:0] t, input bit le, input logic [WIDTH-1:0] lv);
    lit_en  = le;
    lit_val = lv;
    step(1'b1, s, c, t, 1'b0, 1'b0);
    lit_en  = 1'b0;
  endtask

  function automatic logic [WIDTH-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  initial begin
    in_valid = 1'b0; in_sum = '0; in_carry = '0; in_tag = '0; flush = 1'b0; reset = 1'b1;
    @(negedge clock);
    step(1'b0, '0, '0, '0, 1'b0, 1'b1);

    // Reset, then 10 idle cycles: every output stays at zero.
    idle_chk = 1'b1;
    idle(10);
    idle_chk = 1'b0;

    // The carry crosses from chunk 0 into chunk 1.
    op(64'h0000_0000_0000_FFFF, 64'h1, 4'd3, 1'b1, 64'h0000_0000_0001_0000);
    idle(6);

    // The carry ripples through every chunk, and the carry-out is dropped.
    op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 4'd5, 1'b1, 64'h0);
    op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 4'd6, 1'b1, 64'h0);
    idle(6);

    // Stream of 8 operations with one bubble after tag 4.
    for (int t = 0; t < 8; t++) begin
      op(rnd64(), rnd64(), 4'(t), 1'b0, '0);
      if (t == 4) idle(1);
    end
    idle(6);

    // Flush with 3 operations in flight and a 4th presented in the same
    // cycle. The operation issued right after the flush must come out.
    op(rnd64(), rnd64(), 4'd8, 1'b0, '0);
    op(rnd64(), rnd64(), 4'd9, 1'b0, '0);
    op(rnd64(), rnd64(), 4'd10, 1'b0, '0);
    step(1'b1, rnd64(), rnd64(), 4'd11, 1'b1, 1'b0);
    op(64'h0000_0001_0000_0000, 64'h0000_0002_0000_0000, 4'd12, 1'b1, 64'h0000_0003_0000_0000);
    idle(6);

    // Performance counter: 5 results, then a reset in mid-stream, then a flush.
    step(1'b0, '0, '0, '0, 1'b0, 1'b1);
    for (int t = 0; t < 5; t++) op(rnd64(), rnd64(), 4'(t), 1'b0, '0);
    idle(6);
`ifdef CSA_FINAL_ADDER_PERF_EN
    chk("perf_after_5", {32'd0, perf_count}, 64'd5);
`endif
    op(rnd64(), rnd64(), 4'd13, 1'b0, '0);
    op(rnd64(), rnd64(), 4'd14, 1'b0, '0);
    step(1'b1, rnd64(), rnd64(), 4'd15, 1'b0, 1'b1);
`ifdef CSA_FINAL_ADDER_PERF_EN
    chk("perf_after_reset", {32'd0, perf_count}, 64'd0);
`endif
    idle(6);
    op(64'h0000_0000_0000_0007, 64'h0000_0000_0000_0009, 4'd1, 1'b1, 64'h10);
    idle(6);
    op(rnd64(), rnd64(), 4'd2, 1'b0, '0);
    step(1'b0, '0, '0, '0, 1'b1, 1'b0);
    idle(6);
`ifdef CSA_FINAL_ADDER_PERF_EN
    chk("perf_after_flush", {32'd0, perf_count}, 64'd1);
`endif

    // Results expected in total: 1 + 2 + 8 + 1 + 5 + 1.
    chk("total_results", 64'(seen), 64'd18);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
